// File: rtl/time_disp_pkg.sv
// Shared types and constants for the time display driver: FSM states,
// active-low 7-segment lookup and the double-dabble nibble correction.
package time_disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } disp_state_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam int         BCD_MAX   = 999;

    // Active-low {g,f,e,d,c,b,a}; entry 15 on the left, non-BCD codes blank.
    localparam logic [15:0][6:0] SEG_LUT = {
        SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK, SEG_BLANK,
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [11:0] dd_adjust(input logic [11:0] scratch);
        logic [11:0] result;
        logic [3:0]  nib;
        result = scratch;
        for (int i = 0; i < 3; i++) begin
            nib = scratch[4*i +: 4];
            if (nib >= 4'd5) begin
                result[4*i +: 4] = nib + 4'd3;
            end else begin
                result[4*i +: 4] = nib;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit BCD digit to active-low 7-segment pattern.
module seg7_decode
    import time_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[digit];

endmodule

// File: rtl/time_display_driver.sv
// Converts the countdown time to three BCD digits and drives blinking 7-segment
// displays. Optional macro DISP_LEAD_ZERO_BLANK_EN blanks a leading zero tens digit.
module time_display_driver
    import time_disp_pkg::*;
#(
    parameter int IN_W        = 10,
    parameter int BLINK_TICKS = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IN_W-1:0] time_in,
    input  logic            stop,
    input  logic            ms100,
    output logic [6:0]      seg_tens,
    output logic [6:0]      seg_ones,
    output logic [6:0]      seg_tenths,
    output logic [11:0]     bcd_out,
    output logic            busy
);

    localparam int              CNT_W      = $clog2(IN_W + 1);
    localparam int              BLK_W      = $clog2(BLINK_TICKS + 1);
    localparam logic [IN_W-1:0] SAMPLE_MAX = IN_W'(BCD_MAX);

    disp_state_t     state_r;
    disp_state_t     state_next_s;
    logic [IN_W-1:0] last_r;
    logic [IN_W-1:0] sample_r;
    logic [IN_W-1:0] clamp_s;
    logic [11:0]     scratch_r;
    logic [11:0]     adj_s;
    logic [11:0]     shifted_s;
    logic [CNT_W-1:0] bit_cnt_r;
    logic            busy_r;
    logic [11:0]     bcd_r;
    logic [6:0]      seg_tens_r;
    logic [6:0]      seg_ones_r;
    logic [6:0]      seg_tenths_r;
    logic [BLK_W-1:0] blink_cnt_r;
    logic [BLK_W-1:0] blink_cnt_next_s;
    logic            blank_r;
    logic            blank_next_s;
    logic            changed_s;
    logic [11:0]     disp_bcd_s;
    logic [6:0]      dec_tens_s;
    logic [6:0]      dec_ones_s;
    logic [6:0]      dec_tenths_s;
    logic [6:0]      tens_vis_s;

    assign changed_s = (time_in != last_r);
    assign clamp_s   = (time_in > SAMPLE_MAX) ? SAMPLE_MAX : time_in;
    assign adj_s     = dd_adjust(scratch_r);
    assign shifted_s = (adj_s << 1) | {11'd0, sample_r[IN_W-1]};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: IDLE -> SHIFT on a new value, IN_W shifts, one DONE cycle
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (changed_s) begin
                    state_next_s = SHIFT;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SHIFT: begin
                if (bit_cnt_r == CNT_W'(IN_W - 1)) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = SHIFT;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Conversion datapath: sample latch, double-dabble shift, result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_r    <= '0;
            sample_r  <= '0;
            scratch_r <= 12'd0;
            bit_cnt_r <= '0;
            busy_r    <= 1'b0;
            bcd_r     <= 12'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (changed_s) begin
                        sample_r  <= clamp_s;
                        last_r    <= time_in;
                        scratch_r <= 12'd0;
                        bit_cnt_r <= '0;
                        busy_r    <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch_r <= shifted_s;
                    sample_r  <= sample_r << 1;
                    bit_cnt_r <= bit_cnt_r + CNT_W'(1);
                end
                DONE: begin
                    bcd_r  <= scratch_r;
                    busy_r <= 1'b0;
                end
                default: busy_r <= 1'b0;
            endcase
        end
    end

    // Blink timebase: counts ms100 pulses while stopped, toggles the blank phase
    always_comb begin
        blink_cnt_next_s = blink_cnt_r;
        blank_next_s     = blank_r;
        if (!stop) begin
            blink_cnt_next_s = '0;
            blank_next_s     = 1'b0;
        end else if (ms100) begin
            if (blink_cnt_r == BLK_W'(BLINK_TICKS - 1)) begin
                blink_cnt_next_s = '0;
                blank_next_s     = ~blank_r;
            end else begin
                blink_cnt_next_s = blink_cnt_r + BLK_W'(1);
                blank_next_s     = blank_r;
            end
        end else begin
            blink_cnt_next_s = blink_cnt_r;
            blank_next_s     = blank_r;
        end
    end

    // Blink state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_r <= '0;
            blank_r     <= 1'b0;
        end else begin
            blink_cnt_r <= blink_cnt_next_s;
            blank_r     <= blank_next_s;
        end
    end

    // Segments follow the scratch value in DONE so they change with bcd_out
    always_comb begin
        if (state_r == DONE) begin
            disp_bcd_s = scratch_r;
        end else begin
            disp_bcd_s = bcd_r;
        end
    end

    seg7_decode u_dec_tens   (.digit(disp_bcd_s[11:8]), .seg(dec_tens_s));
    seg7_decode u_dec_ones   (.digit(disp_bcd_s[7:4]),  .seg(dec_ones_s));
    seg7_decode u_dec_tenths (.digit(disp_bcd_s[3:0]),  .seg(dec_tenths_s));

    // Tens digit visible pattern, optionally suppressing a leading zero
    always_comb begin
`ifdef DISP_LEAD_ZERO_BLANK_EN
        if (disp_bcd_s[11:8] == 4'd0) begin
            tens_vis_s = SEG_BLANK;
        end else begin
            tens_vis_s = dec_tens_s;
        end
`else
        tens_vis_s = dec_tens_s;
`endif
    end

    // Segment output registers, blanked using the upcoming blink phase
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_tens_r   <= SEG_ZERO;
            seg_ones_r   <= SEG_ZERO;
            seg_tenths_r <= SEG_ZERO;
        end else if (blank_next_s) begin
            seg_tens_r   <= SEG_BLANK;
            seg_ones_r   <= SEG_BLANK;
            seg_tenths_r <= SEG_BLANK;
        end else begin
            seg_tens_r   <= tens_vis_s;
            seg_ones_r   <= dec_ones_s;
            seg_tenths_r <= dec_tenths_s;
        end
    end

    assign seg_tens   = seg_tens_r;
    assign seg_ones   = seg_ones_r;
    assign seg_tenths = seg_tenths_r;
    assign bcd_out    = bcd_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_time_display_driver.sv
// Directed, table-driven bench for time_display_driver with hand-computed
// BCD and active-low segment expectations.
module tb_time_display_driver;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'h7F;
`ifdef DISP_LEAD_ZERO_BLANK_EN
    localparam logic [6:0] TZ = 7'h7F;
`else
    localparam logic [6:0] TZ = 7'b1000000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  time_in = 10'd0;
    logic        stop = 1'b0;
    logic        ms100 = 1'b0;
    logic [6:0]  seg_tens, seg_ones, seg_tenths;
    logic [11:0] bcd_out;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic [9:0]  tin;
        logic [11:0] bcd;
        logic [6:0]  st;
        logic [6:0]  so;
        logic [6:0]  sx;
    } vec_t;

    vec_t vecs [10];

    time_display_driver dut (
        .clk(clk), .rst(rst), .time_in(time_in), .stop(stop), .ms100(ms100),
        .seg_tens(seg_tens), .seg_ones(seg_ones), .seg_tenths(seg_tenths),
        .bcd_out(bcd_out), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic check_segs(input string name, input logic [6:0] t, input logic [6:0] o, input logic [6:0] x);
        check({name, "_tens"}, {25'd0, seg_tens}, {25'd0, t});
        check({name, "_ones"}, {25'd0, seg_ones}, {25'd0, o});
        check({name, "_tenths"}, {25'd0, seg_tenths}, {25'd0, x});
    endtask

    task automatic pulse();
        ms100 = 1'b1;
        tick();
        ms100 = 1'b0;
        repeat (9) tick();
    endtask

    initial begin
        vecs[0] = '{10'd600,  12'h600, S6, S0, S0};
        vecs[1] = '{10'd0,    12'h000, TZ, S0, S0};
        vecs[2] = '{10'd123,  12'h123, S1, S2, S3};
        vecs[3] = '{10'd871,  12'h871, S8, S7, S1};
        vecs[4] = '{10'd1023, 12'h999, S9, S9, S9};
        vecs[5] = '{10'd1000, 12'h999, S9, S9, S9};
        vecs[6] = '{10'd999,  12'h999, S9, S9, S9};
        vecs[7] = '{10'd458,  12'h458, S4, S5, S8};
        vecs[8] = '{10'd7,    12'h007, TZ, S0, S7};
        vecs[9] = '{10'd45,   12'h045, TZ, S4, S5};

        // reset state
        repeat (2) tick();
        check("rst_bcd", {20'd0, bcd_out}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check_segs("rst", S0, S0, S0);
        rst = 1'b0;
        repeat (3) tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // table: latency 12, busy high for 11 cycles, no re-conversion afterwards
        for (int i = 0; i < 10; i++) begin
            time_in = vecs[i].tin;
            for (int c = 1; c <= 11; c++) begin
                tick();
                check($sformatf("v%0d_busy_c%0d", i, c), {31'd0, busy}, 32'd1);
            end
            tick();
            check($sformatf("v%0d_busy_done", i), {31'd0, busy}, 32'd0);
            check($sformatf("v%0d_bcd", i), {20'd0, bcd_out}, {20'd0, vecs[i].bcd});
            check_segs($sformatf("v%0d", i), vecs[i].st, vecs[i].so, vecs[i].sx);
            repeat (4) tick();
            check($sformatf("v%0d_no_retrig", i), {31'd0, busy}, 32'd0);
        end

        // time_in walks 610 down to 599 during busy; final value must be shown
        begin
            int waited;
            time_in = 10'd610;
            for (int k = 0; k < 11; k++) begin
                tick();
                time_in = time_in - 10'd1;
            end
            waited = 0;
            while (!(busy == 1'b0 && bcd_out == 12'h599) && waited < 60) begin
                tick();
                waited++;
            end
            check("walk_timeout", (waited < 60) ? 32'd1 : 32'd0, 32'd1);
            check("walk_bcd", {20'd0, bcd_out}, 32'h599);
            check_segs("walk", S5, S9, S9);
            repeat (5) tick();
            check("walk_idle", {31'd0, busy}, 32'd0);
        end

        // blink: stop rises together with the first pulse
        stop = 1'b1;
        repeat (4) pulse();
        check_segs("blink4", S5, S9, S9);
        pulse();
        check_segs("blink5", SB, SB, SB);
        check("blink5_bcd", {20'd0, bcd_out}, 32'h599);
        repeat (4) pulse();
        check_segs("blink9", SB, SB, SB);
        pulse();
        check_segs("blink10", S5, S9, S9);
        repeat (3) pulse();
        stop = 1'b0;
        tick();
        check_segs("stopfall_a", S5, S9, S9);
        stop = 1'b1;
        repeat (4) pulse();
        check_segs("cnt_cleared", S5, S9, S9);
        pulse();
        check_segs("reblank", SB, SB, SB);
        stop = 1'b0;
        tick();
        check_segs("stopfall_b", S5, S9, S9);

        // async reset in the middle of SHIFT
        time_in = 10'd300;
        repeat (4) tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_bcd", {20'd0, bcd_out}, 32'h0);
        check_segs("arst", S0, S0, S0);
        time_in = 10'd45;
        tick();
        rst = 1'b0;
        repeat (11) tick();
        check("post_rst_busy", {31'd0, busy}, 32'd1);
        tick();
        check("post_rst_bcd", {20'd0, bcd_out}, 32'h045);
        check_segs("post_rst", TZ, S4, S5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
